alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester 0/1 operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester 0/1.
REQ-007 req0_op / req1_op  input  4  operation code: 0000 add, 0001 sub, 0010 and, 0011 or.
REQ-008 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-009 alu_control  output  4  operation code driven to the shared ALU.
REQ-010 alu_result  input  WIDTH  combinational ALU result.
REQ-011 alu_zero, alu_overflow  input  1  combinational ALU flags.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer takes response this cycle.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_result  output  WIDTH  registered result.
REQ-016 rsp_zero, rsp_overflow, rsp_err  output  1  registered flags; rsp_err marks an illegal opcode.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-018 IDLE: if any req valid, grant one requester, assert only its reqN_ready combinationally, latch its a, b, op and index into internal registers, go to EXEC; else stay in IDLE.
REQ-019 reqN_ready is 0 in EXEC and RESP and for the non-granted requester.
REQ-020 Arbitration is round-robin: a 1-bit priority pointer names the preferred requester; on each acceptance, pointer becomes the index not granted.
REQ-021 Single requester valid: granted regardless of the pointer.
REQ-022 EXEC (exactly one cycle): alu_a, alu_b, alu_control driven from the latched registers; at the end of the cycle, capture alu_result, alu_zero, alu_overflow into the rsp registers, set rsp_err=0, go to RESP.
REQ-023 Illegal opcode (op[3:2] != 00): alu_control is driven to 0000; captured values are result 0, zero 0, overflow 0, rsp_err 1.
REQ-024 In IDLE and RESP, alu_a, alu_b and alu_control hold the last latched values (no glitching to new requester data).
REQ-025 RESP: rsp_valid=1; rsp_id, rsp_result and all flags are held stable until rsp_ready=1; on rsp_ready=1, go to IDLE in the next cycle.
REQ-026 Latency: an acceptance in cycle N gives rsp_valid=1 in cycle N+2; minimum issue interval is 3 cycles.
REQ-027 rsp_ready asserted outside RESP has no effect.
REQ-028 Arithmetic is WIDTH-bit wraparound; overflow and zero are passed through from the ALU unmodified.
REQ-029 A requester may drop valid without being granted; no state change results.

Reset
REQ-030 rst_n=0 immediately forces: state IDLE, pointer 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp flags 0, latched operands/op 0 (so alu_a, alu_b and alu_control are 0).
REQ-031 Reset mid-operation (EXEC or RESP) discards the operation; no response is produced after rst_n rises.
REQ-032 The first acceptance after reset is in the first clk edge with rst_n=1 and a valid request.

Verification
REQ-033 Single op: req0 a=10, b=20, op=0000 accepted at cycle N -> cycle N+2: rsp_valid=1, rsp_id=0, result=30, zero=0, overflow=0, err=0.
REQ-034 Contention: both valid continuously after reset, req0 sub 50-50, req1 add 0x7FFFFFFFFFFFFFFF+1 -> grants alternate 0,1,0,...; req0 response result 0, zero=1; req1 response result 0x8000000000000000, overflow=1.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and all rsp fields stable; both reqN_ready stay 0; transfer completes on the first rsp_ready=1.
REQ-036 Illegal op: req1 op=0101, a=1, b=1 -> rsp_id=1, rsp_err=1, result 0, zero 0, overflow 0; alu_control=0000 during EXEC.
REQ-037 Reset in RESP: rst_n pulsed low with rsp_valid=1 -> rsp_valid=0 asynchronously, pointer 0; a later req0 and req1 both valid -> req0 granted first.
REQ-038 Logic ops: a=0b1010, b=0b1100, op 0010 -> result 0b1000; op 0011 -> result 0b1110; issue interval measured as 3 cycles with rsp_ready tied 1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, shared-ALU and response signals around alu_arbiter.
// The arbiter uses the slave view; the environment driving requests uses master.
`timescale 1ns/1ps
interface alu_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_overflow;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero, alu_overflow, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_control,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero, alu_overflow, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_control,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU:
// accept one operation, drive the ALU for a cycle, hold the response until taken.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q;
    logic             ptr_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic             err_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_ovf_q;
    logic             rsp_err_q;

    logic             any_valid;
    logic             grant_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [3:0]       op_d;
    logic             err_d;
    logic [3:0]       ctrl_d;

    // NOTE: every signal is assigned on every pass through this block, so no latch is inferred.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        // Pointer only matters when both ask; a lone requester always wins.
        grant_d   = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
        a_d       = grant_d ? bus.req1_a  : bus.req0_a;
        b_d       = grant_d ? bus.req1_b  : bus.req0_b;
        op_d      = grant_d ? bus.req1_op : bus.req0_op;
        err_d     = (op_d[3:2] != 2'b00);
        ctrl_d    = err_d ? 4'b0000 : op_d;
    end

    assign bus.req0_ready   = (state_q == IDLE) & any_valid & ~grant_d;
    assign bus.req1_ready   = (state_q == IDLE) & any_valid &  grant_d;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_control  = ctrl_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.rsp_err      = rsp_err_q;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= 4'b0000;
            err_q        <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        ctrl_q  <= ctrl_d;
                        err_q   <= err_d;
                        id_q    <= grant_d;
                        ptr_q   <= ~grant_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal opcodes report a clean zero result instead of the ALU's add.
                    rsp_result_q <= err_q ? '0 : bus.alu_result;
                    rsp_zero_q   <= err_q ? 1'b0 : bus.alu_zero;
                    rsp_ovf_q    <= err_q ? 1'b0 : bus.alu_overflow;
                    rsp_err_q    <= err_q;
                    rsp_id_q     <= id_q;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every falling edge,
// plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int W = 64;
    typedef logic [W-1:0] word_t;
    typedef struct packed {
        logic  id;
        word_t result;
        logic  zero;
        logic  ovf;
        logic  err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;

    alu_arbiter_if #(.WIDTH(W)) bus_if ();
    alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Shared ALU: signed overflow taken from a sign-extended (W+1)-bit result.
    logic [W:0] alu_ext;
    word_t      alu_res;
    logic       alu_ovf;
    always_comb begin
        alu_ext = '0;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus_if.alu_control)
            4'd0: begin
                alu_ext = {bus_if.alu_a[W-1], bus_if.alu_a} + {bus_if.alu_b[W-1], bus_if.alu_b};
                alu_res = alu_ext[W-1:0];
                alu_ovf = alu_ext[W] ^ alu_ext[W-1];
            end
            4'd1: begin
                alu_ext = {bus_if.alu_a[W-1], bus_if.alu_a} - {bus_if.alu_b[W-1], bus_if.alu_b};
                alu_res = alu_ext[W-1:0];
                alu_ovf = alu_ext[W] ^ alu_ext[W-1];
            end
            4'd2:    alu_res = bus_if.alu_a & bus_if.alu_b;
            4'd3:    alu_res = bus_if.alu_a | bus_if.alu_b;
            default: alu_res = '0;
        endcase
        bus_if.alu_result   = alu_res;
        bus_if.alu_zero     = (alu_res == '0);
        bus_if.alu_overflow = alu_ovf;
    end

    function automatic rsp_t golden(input logic id, input logic [3:0] op, input word_t a, input word_t b);
        rsp_t  r;
        word_t v;
        r    = '0;
        r.id = id;
        if (op[3:2] != 2'b00) begin
            r.err = 1'b1;
            return r;
        end
        v = '0;
        case (op[1:0])
            2'd0: begin v = a + b; r.ovf = (a[W-1] == b[W-1]) && (v[W-1] != a[W-1]); end
            2'd1: begin v = a - b; r.ovf = (a[W-1] != b[W-1]) && (v[W-1] != a[W-1]); end
            2'd2: v = a & b;
            default: v = a | b;
        endcase
        r.result = v;
        r.zero   = (v == '0);
        return r;
    endfunction

    // Model: free/busy with cycles since acceptance; response due two cycles after it.
    logic       m_busy;
    int         m_age;
    logic       m_ptr;
    word_t      m_last_a;
    word_t      m_last_b;
    logic [3:0] m_last_ctrl;
    rsp_t       m_exp;
    logic       m_v0, m_v1, m_g, m_rsp;
    logic [3:0] m_op;
    int         grants[$];
    word_t      seen_result[2];
    logic       seen_zero[2];
    logic       seen_ovf[2];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_ptr = 1'b0;
            m_last_a = '0; m_last_b = '0; m_last_ctrl = 4'd0;
            check("rst_rsp_valid", bus_if.rsp_valid, 0);
            check("rst_rsp_id", bus_if.rsp_id, 0);
            check("rst_rsp_result", bus_if.rsp_result, 0);
            check("rst_rsp_flags", {bus_if.rsp_zero, bus_if.rsp_overflow, bus_if.rsp_err}, 0);
            check("rst_alu_a", bus_if.alu_a, 0);
            check("rst_alu_b", bus_if.alu_b, 0);
            check("rst_alu_control", bus_if.alu_control, 0);
        end else begin
            m_v0 = bus_if.req0_valid;
            m_v1 = bus_if.req1_valid;
            m_g  = (m_v0 && m_v1) ? m_ptr : m_v1;
            check("req0_ready", bus_if.req0_ready, !m_busy && (m_v0 || m_v1) && !m_g);
            check("req1_ready", bus_if.req1_ready, !m_busy && (m_v0 || m_v1) && m_g);
            check("alu_a", bus_if.alu_a, m_last_a);
            check("alu_b", bus_if.alu_b, m_last_b);
            check("alu_control", bus_if.alu_control, m_last_ctrl);
            m_rsp = m_busy && (m_age >= 2);
            check("rsp_valid", bus_if.rsp_valid, m_rsp);
            if (m_rsp) begin
                check("rsp_id", bus_if.rsp_id, m_exp.id);
                check("rsp_result", bus_if.rsp_result, m_exp.result);
                check("rsp_zero", bus_if.rsp_zero, m_exp.zero);
                check("rsp_overflow", bus_if.rsp_overflow, m_exp.ovf);
                check("rsp_err", bus_if.rsp_err, m_exp.err);
                seen_result[bus_if.rsp_id] = bus_if.rsp_result;
                seen_zero[bus_if.rsp_id]   = bus_if.rsp_zero;
                seen_ovf[bus_if.rsp_id]    = bus_if.rsp_overflow;
            end
            if (bus_if.req0_ready) grants.push_back(0);
            if (bus_if.req1_ready) grants.push_back(1);
            if (!m_busy) begin
                if (m_v0 || m_v1) begin
                    m_op        = m_g ? bus_if.req1_op : bus_if.req0_op;
                    m_last_a    = m_g ? bus_if.req1_a : bus_if.req0_a;
                    m_last_b    = m_g ? bus_if.req1_b : bus_if.req0_b;
                    m_last_ctrl = (m_op[3:2] == 2'b00) ? m_op : 4'd0;
                    m_exp       = golden(m_g, m_op, m_last_a, m_last_b);
                    m_ptr       = ~m_g;
                    m_busy      = 1'b1;
                    m_age       = 1;
                end
            end else if (m_age >= 2 && bus_if.rsp_ready) begin
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input logic v, input logic [3:0] op, input word_t a, input word_t b);
        if (who == 0) begin
            bus_if.req0_valid = v; bus_if.req0_op = op; bus_if.req0_a = a; bus_if.req0_b = b;
        end else begin
            bus_if.req1_valid = v; bus_if.req1_op = op; bus_if.req1_a = a; bus_if.req1_b = b;
        end
    endtask

    // Returns just after the accepting edge (DUT now in EXEC), with that cycle count.
    task automatic wait_accept(input int who, output int at_cycle);
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((who == 0 && bus_if.req0_ready) || (who == 1 && bus_if.req1_ready)) begin
                @(posedge clk);
                #1;
                at_cycle = cycle;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: requester %0d never granted, expected grant within 20 cycles", who);
        at_cycle = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000ns, expected completion");
        $fatal(1);
    end

    int t, t1, t2, rel;

    initial begin
        set_req(0, 0, 4'd0, '0, '0);
        set_req(1, 0, 4'd0, '0, '0);
        bus_if.rsp_ready = 1'b1;
        tick(3);

        // Single add, first acceptance on the first edge out of reset.
        rst_n = 1'b1;
        rel = cycle;
        set_req(0, 1, 4'b0000, 64'd10, 64'd20);
        wait_accept(0, t);
        check("first_accept_cycle", t, rel + 1);
        set_req(0, 0, 4'b0000, 64'd10, 64'd20);
        #1;
        check("exec_alu_a", bus_if.alu_a, 64'd10);
        check("exec_alu_control", bus_if.alu_control, 4'b0000);
        tick(1);
        check("single_valid", bus_if.rsp_valid, 1);
        check("single_id", bus_if.rsp_id, 0);
        check("single_result", bus_if.rsp_result, 64'd30);
        check("single_flags", {bus_if.rsp_zero, bus_if.rsp_overflow, bus_if.rsp_err}, 0);
        tick(1);

        // Logic ops back to back; issue interval with rsp_ready tied high.
        set_req(0, 1, 4'b0010, 64'b1010, 64'b1100);
        wait_accept(0, t1);
        set_req(0, 1, 4'b0011, 64'b1010, 64'b1100);
        tick(1);
        check("and_result", bus_if.rsp_result, 64'b1000);
        wait_accept(0, t2);
        set_req(0, 0, 4'b0011, 64'b1010, 64'b1100);
        check("issue_interval", t2 - t1, 3);
        tick(1);
        check("or_result", bus_if.rsp_result, 64'b1110);
        tick(1);

        // Illegal opcode from requester 1 (pointer now prefers 1 anyway).
        set_req(1, 1, 4'b0101, 64'd1, 64'd1);
        wait_accept(1, t);
        set_req(1, 0, 4'b0101, 64'd1, 64'd1);
        #1;
        check("illegal_alu_control", bus_if.alu_control, 4'b0000);
        tick(1);
        check("illegal_id", bus_if.rsp_id, 1);
        check("illegal_err", bus_if.rsp_err, 1);
        check("illegal_result", bus_if.rsp_result, 0);
        check("illegal_zero_ovf", {bus_if.rsp_zero, bus_if.rsp_overflow}, 0);
        tick(1);

        // Backpressure: response held five cycles while requester 1 waits.
        bus_if.rsp_ready = 1'b0;
        set_req(0, 1, 4'b0000, 64'd3, 64'd4);
        set_req(1, 1, 4'b0001, 64'd5, 64'd7);
        wait_accept(0, t);
        set_req(0, 0, 4'b0000, 64'd3, 64'd4);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus_if.rsp_valid, 1);
            check("bp_result", bus_if.rsp_result, 64'd7);
            check("bp_ready", {bus_if.req0_ready, bus_if.req1_ready}, 0);
            tick(1);
        end
        bus_if.rsp_ready = 1'b1;
        rel = cycle;
        wait_accept(1, t);
        check("bp_release_grant", t, rel + 2);
        set_req(1, 0, 4'b0001, 64'd5, 64'd7);
        tick(1);
        check("sub_wrap_result", bus_if.rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        tick(1);

        // Reset while a response is pending; pointer returns to requester 0.
        bus_if.rsp_ready = 1'b0;
        set_req(0, 1, 4'b0000, 64'd1, 64'd2);
        wait_accept(0, t);
        set_req(0, 0, 4'b0000, 64'd1, 64'd2);
        tick(1);
        set_req(1, 1, 4'b0010, 64'd6, 64'd3);
        tick(1);
        set_req(1, 0, 4'b0010, 64'd6, 64'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", bus_if.rsp_valid, 0);
        tick(2);
        set_req(0, 1, 4'b0000, 64'd7, 64'd8);
        set_req(1, 1, 4'b0010, 64'd6, 64'd3);
        bus_if.rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("post_reset_grant", {bus_if.req0_ready, bus_if.req1_ready}, 2'b10);
        wait_accept(0, t);
        set_req(0, 0, 4'b0000, 64'd7, 64'd8);
        wait_accept(1, t);
        set_req(1, 0, 4'b0010, 64'd6, 64'd3);
        tick(3);

        // Contention from reset: grants alternate, flags pass through.
        rst_n = 1'b0;
        tick(2);
        grants.delete();
        set_req(0, 1, 4'b0001, 64'd50, 64'd50);
        set_req(1, 1, 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        rst_n = 1'b1;
        tick(12);
        set_req(0, 0, 4'b0001, 64'd50, 64'd50);
        set_req(1, 0, 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        tick(4);
        check("contention_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("contention_grant_order", grants[i], i % 2);
        end
        check("contention_req0_result", seen_result[0], 0);
        check("contention_req0_zero", seen_zero[0], 1);
        check("contention_req1_result", seen_result[1], 64'h8000_0000_0000_0000);
        check("contention_req1_overflow", seen_ovf[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
